// File: rtl/lowmem_burst_arbiter.sv
// ---------------------------------------------------------------------------
// lowmem_burst_arbiter
//
// Shares one burst-capable lowmem port between two cache_cpu masters
// (m0 = I-cache, m1 = D-cache). Each master's one-cycle rd/we pulse is
// captured into a per-master slot, slots are granted round-robin, and the
// granted command is replayed downstream as a one-cycle s_rd/s_we pulse.
// The grant is then held for the whole burst by counting s_ready beats.
//
// Parameters
//   BURST_LEN_W  width of burst_length; a length of 0 means 2**BURST_LEN_W
//   FIRST_PRIO   master that wins a simultaneous request after reset
//
// Ports
//   clk, rst               clock; synchronous active-high reset
//   mN_a / mN_d            master N address / live write data
//   mN_we / mN_rd          master N one-cycle write / read request
//   mN_burst_en/_length    master N burst enable / beats per burst
//   mN_spo                 read data (s_spo broadcast to both masters)
//   mN_ready               per-beat ready, only for the granted master
//   s_a / s_d              downstream address / write data
//   s_we / s_rd            downstream one-cycle command pulse
//   s_burst_en/_length     downstream burst enable / length
//   s_spo / s_ready        downstream read data / per-beat ready
//   grant                  granted (or last granted) master index
//   busy                   arbiter is issuing or transferring
//   proto_err              sticky per-master dropped-request flag
// ---------------------------------------------------------------------------
module lowmem_burst_arbiter #(
    parameter int unsigned BURST_LEN_W = 8,
    parameter int unsigned FIRST_PRIO  = 0
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic [31:0]            m0_a,
    input  logic [31:0]            m0_d,
    input  logic                   m0_we,
    input  logic                   m0_rd,
    input  logic                   m0_burst_en,
    input  logic [BURST_LEN_W-1:0] m0_burst_length,
    output logic [31:0]            m0_spo,
    output logic                   m0_ready,

    input  logic [31:0]            m1_a,
    input  logic [31:0]            m1_d,
    input  logic                   m1_we,
    input  logic                   m1_rd,
    input  logic                   m1_burst_en,
    input  logic [BURST_LEN_W-1:0] m1_burst_length,
    output logic [31:0]            m1_spo,
    output logic                   m1_ready,

    output logic [31:0]            s_a,
    output logic [31:0]            s_d,
    output logic                   s_we,
    output logic                   s_rd,
    output logic                   s_burst_en,
    output logic [BURST_LEN_W-1:0] s_burst_length,
    input  logic [31:0]            s_spo,
    input  logic                   s_ready,

    output logic                   grant,
    output logic                   busy,
    output logic [1:0]             proto_err
);

    localparam int unsigned CW      = BURST_LEN_W + 1;
    localparam logic        FIRST_M = 1'(FIRST_PRIO);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        XFER
    } state_t;

    state_t                 state;
    logic [CW-1:0]          beat_cnt;
    logic                   prio_fresh;   // no grant made since reset
    logic [31:0]            s_d_q;        // write data presented during ISSUE

    // Per-master request slots
    logic [1:0]             slot_v;
    logic [1:0]             slot_we;
    logic [1:0]             slot_be;
    logic [31:0]            slot_a   [2];
    logic [31:0]            slot_d   [2];
    logic [BURST_LEN_W-1:0] slot_len [2];

    // Master inputs gathered into index-addressable form
    logic [31:0]            in_a   [2];
    logic [31:0]            in_d   [2];
    logic [BURST_LEN_W-1:0] in_len [2];
    logic [1:0]             in_we;
    logic [1:0]             in_be;

    logic [1:0]             req;
    logic [1:0]             inflight;
    logic [1:0]             capture;
    logic [1:0]             drop;
    logic                   cmd_inflight;
    logic                   last_beat;
    logic                   pick;

    assign in_a[0]   = m0_a;
    assign in_a[1]   = m1_a;
    assign in_d[0]   = m0_d;
    assign in_d[1]   = m1_d;
    assign in_len[0] = m0_burst_length;
    assign in_len[1] = m1_burst_length;
    // we & rd together is a write
    assign in_we     = {m1_we, m0_we};
    assign in_be     = {m1_burst_en, m0_burst_en};

    assign last_beat = (state == XFER) && s_ready && (beat_cnt == CW'(1));

    always_comb begin
        // The granted master stops being in flight during its final beat,
        // so a request in the cycle its burst ends is captured.
        cmd_inflight = (state == ISSUE) || ((state == XFER) && !last_beat);
        inflight     = {cmd_inflight && grant, cmd_inflight && !grant};
        req          = {m1_we | m1_rd, m0_we | m0_rd};
        capture      = req & ~slot_v & ~inflight;
        drop         = req & (slot_v | inflight);

        if (slot_v == 2'b11) begin
            pick = prio_fresh ? FIRST_M : ~grant;
        end else begin
            pick = slot_v[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            beat_cnt       <= '0;
            prio_fresh     <= 1'b1;
            grant          <= FIRST_M;
            proto_err      <= '0;
            s_a            <= '0;
            s_d_q          <= '0;
            s_we           <= 1'b0;
            s_rd           <= 1'b0;
            s_burst_en     <= 1'b0;
            s_burst_length <= '0;
            slot_v         <= '0;
            slot_we        <= '0;
            slot_be        <= '0;
            slot_a         <= '{default: '0};
            slot_d         <= '{default: '0};
            slot_len       <= '{default: '0};
        end else begin
            for (int unsigned n = 0; n < 2; n++) begin
                if (capture[n[0]]) begin
                    slot_v[n[0]]   <= 1'b1;
                    slot_we[n[0]]  <= in_we[n[0]];
                    slot_be[n[0]]  <= in_be[n[0]];
                    slot_a[n[0]]   <= in_a[n[0]];
                    slot_d[n[0]]   <= in_d[n[0]];
                    slot_len[n[0]] <= in_len[n[0]];
                end
                if (drop[n[0]]) begin
                    proto_err[n[0]] <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (|slot_v) begin
                        grant          <= pick;
                        prio_fresh     <= 1'b0;
                        s_a            <= slot_a[pick];
                        s_d_q          <= slot_d[pick];
                        s_we           <= slot_we[pick];
                        s_rd           <= ~slot_we[pick];
                        s_burst_en     <= slot_be[pick];
                        s_burst_length <= slot_len[pick];
                        state          <= ISSUE;
                    end
                end

                ISSUE: begin
                    s_we          <= 1'b0;
                    s_rd          <= 1'b0;
                    // capture[grant] is blocked in ISSUE, so this clear
                    // never competes with a new capture of the same slot
                    slot_v[grant] <= 1'b0;
                    if (!s_burst_en) begin
                        beat_cnt <= CW'(1);
                    end else if (s_burst_length == '0) begin
                        beat_cnt <= {1'b1, {BURST_LEN_W{1'b0}}};
                    end else begin
                        beat_cnt <= {1'b0, s_burst_length};
                    end
                    state         <= XFER;
                end

                XFER: begin
                    if (s_ready) begin
                        beat_cnt <= beat_cnt - CW'(1);
                        if (beat_cnt == CW'(1)) begin
                            state <= IDLE;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    // During XFER the write data follows the granted master beat by beat
    assign s_d      = (state == XFER) ? (grant ? m1_d : m0_d) : s_d_q;

    assign m0_ready = (state == XFER) && !grant && s_ready;
    assign m1_ready = (state == XFER) &&  grant && s_ready;
    assign m0_spo   = s_spo;
    assign m1_spo   = s_spo;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_lowmem_burst_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lowmem_burst_arbiter
//
// Directed bench for lowmem_burst_arbiter. Expected downstream commands and
// expected per-beat ready/read-data are queued as stimulus is driven and are
// popped by a negedge monitor when the DUT produces them.
// ---------------------------------------------------------------------------
module tb_lowmem_burst_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0_a, m0_d, m1_a, m1_d;
    logic        m0_we, m0_rd, m0_burst_en, m1_we, m1_rd, m1_burst_en;
    logic [7:0]  m0_burst_length, m1_burst_length;
    logic [31:0] m0_spo, m1_spo;
    logic        m0_ready, m1_ready;
    logic [31:0] s_a, s_d, s_spo;
    logic        s_we, s_rd, s_burst_en, s_ready;
    logic [7:0]  s_burst_length;
    logic        grant, busy;
    logic [1:0]  proto_err;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        m;
        logic        we;
        logic        rd;
        logic [31:0] a;
        logic [31:0] d;
        logic        be;
        logic [7:0]  len;
    } cmd_t;

    typedef struct packed {
        logic [1:0]  mask;
        logic [31:0] spo;
        logic        chk_d;
        logic [31:0] d;
    } beat_t;

    cmd_t  cmd_q [$];
    beat_t beat_q [$];
    cmd_t  mon_c;
    beat_t mon_b;

    lowmem_burst_arbiter #(
        .BURST_LEN_W(8),
        .FIRST_PRIO (0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .m0_a           (m0_a),
        .m0_d           (m0_d),
        .m0_we          (m0_we),
        .m0_rd          (m0_rd),
        .m0_burst_en    (m0_burst_en),
        .m0_burst_length(m0_burst_length),
        .m0_spo         (m0_spo),
        .m0_ready       (m0_ready),
        .m1_a           (m1_a),
        .m1_d           (m1_d),
        .m1_we          (m1_we),
        .m1_rd          (m1_rd),
        .m1_burst_en    (m1_burst_en),
        .m1_burst_length(m1_burst_length),
        .m1_spo         (m1_spo),
        .m1_ready       (m1_ready),
        .s_a            (s_a),
        .s_d            (s_d),
        .s_we           (s_we),
        .s_rd           (s_rd),
        .s_burst_en     (s_burst_en),
        .s_burst_length (s_burst_length),
        .s_spo          (s_spo),
        .s_ready        (s_ready),
        .grant          (grant),
        .busy           (busy),
        .proto_err      (proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        m0_we = 1'b0; m0_rd = 1'b0;
        m1_we = 1'b0; m1_rd = 1'b0;
    endtask

    task automatic set_req(input int m, input logic we, input logic [31:0] a,
                           input logic [31:0] d, input logic be, input logic [7:0] len);
        if (m == 0) begin
            m0_a = a; m0_d = d; m0_we = we; m0_rd = !we;
            m0_burst_en = be; m0_burst_length = len;
        end else begin
            m1_a = a; m1_d = d; m1_we = we; m1_rd = !we;
            m1_burst_en = be; m1_burst_length = len;
        end
    endtask

    task automatic expect_cmd(input logic m, input logic we, input logic [31:0] a,
                              input logic [31:0] d, input logic be, input logic [7:0] len);
        cmd_t c;
        c.m = m; c.we = we; c.rd = !we; c.a = a; c.d = d; c.be = be; c.len = len;
        cmd_q.push_back(c);
    endtask

    // Waits (bounded) for the downstream command pulse, checks its latency
    // in cycles from the call, then steps into the XFER cycle.
    task automatic wait_cmd(input string tag, input int exp_lat);
        int lat;
        bit seen;
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (s_rd || s_we) begin
                seen = 1'b1;
                break;
            end
            tick();
            clear_reqs();
            lat++;
        end
        chk({tag, "_latency"}, seen ? lat : 99, exp_lat);
        tick();
        clear_reqs();
    endtask

    // Drives n ready beats (with an idle gap every few beats) for master m.
    task automatic beats(input int m, input int n, input logic [31:0] base, input bit wr);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            if (i % 7 == 3) begin
                s_ready = 1'b0;
                tick();
                clear_reqs();
            end
            s_ready = 1'b1;
            s_spo   = base + 32'(i);
            b.mask  = (m == 1) ? 2'b10 : 2'b01;
            b.spo   = s_spo;
            b.chk_d = wr;
            b.d     = '0;
            if (wr) begin
                b.d = $urandom;
                if (m == 1) m1_d = b.d; else m0_d = b.d;
            end
            beat_q.push_back(b);
            tick();
            clear_reqs();
        end
        s_ready = 1'b0;
        chk("beats_consumed", beat_q.size(), 0);
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        chk({tag, "_busy"}, busy, 1'b0);
        tick();
    endtask

    task automatic check_reset(input string tag);
        @(negedge clk);
        chk({tag, "_s_we"}, s_we, 1'b0);
        chk({tag, "_s_rd"}, s_rd, 1'b0);
        chk({tag, "_s_a"}, s_a, 32'h0);
        chk({tag, "_s_d"}, s_d, 32'h0);
        chk({tag, "_s_burst_en"}, s_burst_en, 1'b0);
        chk({tag, "_s_burst_length"}, s_burst_length, 8'h0);
        chk({tag, "_ready"}, {m1_ready, m0_ready}, 2'b00);
        chk({tag, "_grant"}, grant, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_proto_err"}, proto_err, 2'b00);
        tick();
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (s_we || s_rd) begin
                if (cmd_q.size() == 0) begin
                    chk("cmd_unexpected", {s_we, s_rd}, 2'b00);
                end else begin
                    mon_c = cmd_q.pop_front();
                    chk("cmd_grant", grant, mon_c.m);
                    chk("cmd_we", s_we, mon_c.we);
                    chk("cmd_rd", s_rd, mon_c.rd);
                    chk("cmd_a", s_a, mon_c.a);
                    chk("cmd_d", s_d, mon_c.d);
                    chk("cmd_burst_en", s_burst_en, mon_c.be);
                    chk("cmd_burst_length", s_burst_length, mon_c.len);
                end
            end
            if (m0_ready || m1_ready) begin
                if (beat_q.size() == 0) begin
                    chk("ready_unexpected", {m1_ready, m0_ready}, 2'b00);
                end else begin
                    mon_b = beat_q.pop_front();
                    chk("ready_mask", {m1_ready, m0_ready}, mon_b.mask);
                    chk("m0_spo", m0_spo, mon_b.spo);
                    chk("m1_spo", m1_spo, mon_b.spo);
                    if (mon_b.chk_d) chk("s_d_live", s_d, mon_b.d);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        m0_a = '0; m0_d = '0; m0_burst_en = 1'b0; m0_burst_length = '0;
        m1_a = '0; m1_d = '0; m1_burst_en = 1'b0; m1_burst_length = '0;
        clear_reqs();
        s_ready = 1'b0;
        s_spo   = '0;
        tick();
        tick();
        tick();
        rst = 1'b0;
        check_reset("rst0");

        // T1: m0 32-beat read burst
        expect_cmd(1'b0, 1'b0, 32'h1000, 32'h0, 1'b1, 8'd32);
        set_req(0, 1'b0, 32'h1000, 32'h0, 1'b1, 8'd32);
        wait_cmd("t1", 2);
        beats(0, 32, 32'h1111_0000, 1'b0);
        idle_check("t1");

        // T2: round robin, FIRST_PRIO after reset
        reset_dut();
        expect_cmd(1'b0, 1'b0, 32'h2000, 32'h0, 1'b1, 8'd4);
        expect_cmd(1'b1, 1'b0, 32'h3000, 32'h0, 1'b0, 8'd9);
        set_req(0, 1'b0, 32'h2000, 32'h0, 1'b1, 8'd4);
        set_req(1, 1'b0, 32'h3000, 32'h0, 1'b0, 8'd9);
        wait_cmd("t2a", 2);
        beats(0, 4, 32'h2222_0000, 1'b0);
        wait_cmd("t2b", 1);
        beats(1, 1, 32'h3333_0000, 1'b0);
        expect_cmd(1'b0, 1'b0, 32'h2100, 32'h0, 1'b0, 8'd0);
        set_req(0, 1'b0, 32'h2100, 32'h0, 1'b0, 8'd0);
        wait_cmd("t2c", 2);
        beats(0, 1, 32'h2121_0000, 1'b0);
        expect_cmd(1'b1, 1'b0, 32'h3100, 32'h0, 1'b1, 8'd2);
        expect_cmd(1'b0, 1'b0, 32'h2200, 32'h0, 1'b0, 8'd0);
        set_req(0, 1'b0, 32'h2200, 32'h0, 1'b0, 8'd0);
        set_req(1, 1'b0, 32'h3100, 32'h0, 1'b1, 8'd2);
        wait_cmd("t2d", 2);
        beats(1, 2, 32'h3131_0000, 1'b0);
        wait_cmd("t2e", 1);
        beats(0, 1, 32'h2222_1000, 1'b0);
        idle_check("t2");

        // T3: m1 write (we&rd) captured during m0 burst, live write data
        expect_cmd(1'b0, 1'b0, 32'h4000, 32'h0, 1'b1, 8'd32);
        set_req(0, 1'b0, 32'h4000, 32'h0, 1'b1, 8'd32);
        wait_cmd("t3a", 2);
        beats(0, 10, 32'h4444_0000, 1'b0);
        expect_cmd(1'b1, 1'b1, 32'h5000, 32'hCAFE_0001, 1'b1, 8'd4);
        set_req(1, 1'b1, 32'h5000, 32'hCAFE_0001, 1'b1, 8'd4);
        m1_rd = 1'b1;
        beats(0, 22, 32'h4444_1000, 1'b0);
        wait_cmd("t3b", 1);
        beats(1, 4, 32'h5555_0000, 1'b1);
        idle_check("t3");

        // T4: single beat, then stray s_ready while idle
        expect_cmd(1'b0, 1'b0, 32'h6000, 32'h0, 1'b0, 8'd7);
        set_req(0, 1'b0, 32'h6000, 32'h0, 1'b0, 8'd7);
        wait_cmd("t4", 2);
        beats(0, 1, 32'hDEAD_BEEF, 1'b0);
        s_ready = 1'b1;
        @(negedge clk);
        chk("t4_stray_ready", {m1_ready, m0_ready}, 2'b00);
        chk("t4_busy", busy, 1'b0);
        tick();
        s_ready = 1'b0;

        // T5: request from the master whose burst is in flight is dropped
        @(negedge clk);
        chk("t5_err_before", proto_err, 2'b00);
        tick();
        expect_cmd(1'b0, 1'b0, 32'h7000, 32'h0, 1'b1, 8'd8);
        set_req(0, 1'b0, 32'h7000, 32'h0, 1'b1, 8'd8);
        wait_cmd("t5", 2);
        beats(0, 3, 32'h7777_0000, 1'b0);
        set_req(0, 1'b0, 32'h7777, 32'h0, 1'b0, 8'd0);
        beats(0, 5, 32'h7777_1000, 1'b0);
        @(negedge clk);
        chk("t5_err_after", proto_err, 2'b01);
        chk("t5_busy", busy, 1'b0);
        tick();
        repeat (4) tick();

        // T6: reset mid-burst aborts, then normal service
        expect_cmd(1'b0, 1'b0, 32'h8000, 32'h0, 1'b1, 8'd32);
        set_req(0, 1'b0, 32'h8000, 32'h0, 1'b1, 8'd32);
        wait_cmd("t6a", 2);
        beats(0, 10, 32'h8888_0000, 1'b0);
        rst     = 1'b1;
        s_ready = 1'b1;
        tick();
        rst     = 1'b0;
        s_ready = 1'b0;
        check_reset("t6_rst");
        repeat (3) tick();
        expect_cmd(1'b1, 1'b1, 32'h9000, 32'h1234_5678, 1'b0, 8'd3);
        set_req(1, 1'b1, 32'h9000, 32'h1234_5678, 1'b0, 8'd3);
        wait_cmd("t6b", 2);
        beats(1, 1, 32'h9999_0000, 1'b1);
        idle_check("t6");

        // T7: burst_length 0 means 256 beats
        expect_cmd(1'b1, 1'b0, 32'hA000, 32'h0, 1'b1, 8'd0);
        set_req(1, 1'b0, 32'hA000, 32'h0, 1'b1, 8'd0);
        wait_cmd("t7", 2);
        beats(1, 256, 32'hAAAA_0000, 1'b0);
        idle_check("t7");

        chk("cmd_q_drained", cmd_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
